// File: rtl/gpio_cond_pkg.sv
// Shared constants and helpers for the GPIO input conditioner.
package gpio_cond_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
  localparam int DEBOUNCE_CYCLES_TEST    = 1;

  // Debounce counter width: clog2 of the cycle count, never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One GPIO channel: synchronizer chain, debounce counter, clean level and edge pulses.
module gpio_debounce_bit
  import gpio_cond_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter logic INIT_BIT        = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Any cycle where the synchronized level matches the clean level restarts the filter.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], raw_i};
    cnt_d   = '0;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (s != clean_q) begin
      if (cnt_q == CNT_LAST) begin
        clean_d = s;
        rise_d  = s;
        fall_d  = ~s;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= {SYNC_STAGES{INIT_BIT}};
      cnt_q   <= '0;
      clean_q <= INIT_BIT;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign clean_o = clean_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/gpio_input_conditioner.sv
// Murax GPIO-A input stage: per-bit synchronize/debounce plus a pending-change event mask.
module gpio_input_conditioner
  import gpio_cond_pkg::*;
#(
  parameter int               WIDTH           = 8,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter logic [WIDTH-1:0] INIT            = '0
) (
  input  logic             io_mainClk,
  input  logic             io_asyncReset,
  input  logic [WIDTH-1:0] io_raw_in,
  output logic [WIDTH-1:0] io_clean_out,
  output logic [WIDTH-1:0] io_rise_pulse,
  output logic [WIDTH-1:0] io_fall_pulse,
  output logic             io_event_valid,
  output logic [WIDTH-1:0] io_event_mask,
  input  logic             io_event_ready
);

  logic [WIDTH-1:0] pending_q, pending_d;
  logic             accept;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    gpio_debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .INIT_BIT        (INIT[g])
    ) u_bit (
      .clk_i   (io_mainClk),
      .rst_i   (io_asyncReset),
      .raw_i   (io_raw_in[g]),
      .clean_o (io_clean_out[g]),
      .rise_o  (io_rise_pulse[g]),
      .fall_o  (io_fall_pulse[g])
    );
  end

  // Edges landing in the accept cycle are OR-ed in after the clear, so none are lost.
  assign accept = io_event_valid & io_event_ready;

  always_comb begin
    pending_d = (accept ? '0 : pending_q) | io_rise_pulse | io_fall_pulse;
  end

  always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign io_event_mask  = pending_q;
  assign io_event_valid = |pending_q;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed bench for gpio_input_conditioner with WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_gpio_input_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] raw;
  logic [3:0] clean, rise, fall, mask;
  logic       valid, ready;

  int checks = 0;
  int errors = 0;

  gpio_input_conditioner #(
    .WIDTH           (4),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .INIT            (4'b0000)
  ) dut (
    .io_mainClk     (clk),
    .io_asyncReset  (rst),
    .io_raw_in      (raw),
    .io_clean_out   (clean),
    .io_rise_pulse  (rise),
    .io_fall_pulse  (fall),
    .io_event_valid (valid),
    .io_event_mask  (mask),
    .io_event_ready (ready)
  );

  always #5 clk = ~clk;

  // One rising edge, then settle 1 ns before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; raw = 4'b1111; ready = 1'b0;
    repeat (4) begin
      step();
      checks++; if (clean !== 4'b0000) begin errors++; $display("FAIL reset_clean got=%b exp=0000", clean); end
      checks++; if (rise !== 4'b0000 || fall !== 4'b0000) begin errors++; $display("FAIL reset_pulses rise=%b fall=%b exp=0000", rise, fall); end
      checks++; if (valid !== 1'b0 || mask !== 4'b0000) begin errors++; $display("FAIL reset_event valid=%b mask=%b exp=0/0000", valid, mask); end
    end
    raw = 4'b0000;
    step();
    rst = 1'b0;
    repeat (6) step();
    checks++; if (clean !== 4'b0000 || valid !== 1'b0) begin errors++; $display("FAIL reset_release clean=%b valid=%b exp=0000/0", clean, valid); end
  endtask

  task automatic test_clean_step();
    raw[0] = 1'b1;
    repeat (5) step();
    checks++; if (clean !== 4'b0000 || rise !== 4'b0000) begin errors++; $display("FAIL step_edge4 clean=%b rise=%b exp=0000/0000", clean, rise); end
    step();
    checks++; if (clean !== 4'b0001) begin errors++; $display("FAIL step_clean got=%b exp=0001", clean); end
    checks++; if (rise !== 4'b0001 || fall !== 4'b0000) begin errors++; $display("FAIL step_pulse rise=%b fall=%b exp=0001/0000", rise, fall); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL step_valid_early got=%b exp=0", valid); end
    step();
    checks++; if (rise !== 4'b0000) begin errors++; $display("FAIL step_pulse_width rise=%b exp=0000", rise); end
    checks++; if (valid !== 1'b1 || mask !== 4'b0001) begin errors++; $display("FAIL step_event valid=%b mask=%b exp=1/0001", valid, mask); end
    ready = 1'b1;
    step();
    ready = 1'b0;
    checks++; if (valid !== 1'b0 || mask !== 4'b0000) begin errors++; $display("FAIL step_ack valid=%b mask=%b exp=0/0000", valid, mask); end
  endtask

  task automatic test_bounce();
    raw[1] = 1'b1;
    repeat (3) step();
    raw[1] = 1'b0;
    repeat (8) begin
      step();
      checks++; if (clean !== 4'b0001 || rise !== 4'b0000 || valid !== 1'b0) begin errors++; $display("FAIL bounce clean=%b rise=%b valid=%b exp=0001/0000/0", clean, rise, valid); end
    end
    raw[1] = 1'b1;
    repeat (6) step();
    checks++; if (clean !== 4'b0011 || rise !== 4'b0010) begin errors++; $display("FAIL bounce_stable clean=%b rise=%b exp=0011/0010", clean, rise); end
    step();
    checks++; if (valid !== 1'b1 || mask !== 4'b0010) begin errors++; $display("FAIL bounce_event valid=%b mask=%b exp=1/0010", valid, mask); end
    ready = 1'b1;
    step();
    ready = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL bounce_ack valid=%b exp=0", valid); end
  endtask

  task automatic test_collision();
    raw[2] = 1'b1;
    repeat (6) step();
    checks++; if (clean !== 4'b0111 || rise !== 4'b0100) begin errors++; $display("FAIL coll_prep clean=%b rise=%b exp=0111/0100", clean, rise); end
    step();
    ready = 1'b1;
    step();
    ready = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL coll_prep_ack valid=%b exp=0", valid); end
    raw[0] = 1'b0;
    step();
    raw[2] = 1'b0;
    repeat (5) step();
    checks++; if (fall !== 4'b0001 || clean !== 4'b0110) begin errors++; $display("FAIL coll_fall0 fall=%b clean=%b exp=0001/0110", fall, clean); end
    step();
    checks++; if (fall !== 4'b0100 || mask !== 4'b0001 || valid !== 1'b1) begin errors++; $display("FAIL coll_setup fall=%b mask=%b valid=%b exp=0100/0001/1", fall, mask, valid); end
    ready = 1'b1;
    step();
    checks++; if (mask !== 4'b0100 || valid !== 1'b1 || fall !== 4'b0000) begin errors++; $display("FAIL coll_survive mask=%b valid=%b fall=%b exp=0100/1/0000", mask, valid, fall); end
    step();
    ready = 1'b0;
    checks++; if (valid !== 1'b0 || mask !== 4'b0000) begin errors++; $display("FAIL coll_drain valid=%b mask=%b exp=0/0000", valid, mask); end
  endtask

  task automatic test_reset_mid();
    raw = 4'b1000;
    repeat (4) step();
    rst = 1'b1;
    #2;
    checks++; if (clean !== 4'b0000 || rise !== 4'b0000 || fall !== 4'b0000 || valid !== 1'b0) begin errors++; $display("FAIL mid_reset clean=%b rise=%b fall=%b valid=%b exp=0000/0000/0000/0", clean, rise, fall, valid); end
    rst = 1'b0;
    repeat (5) begin
      step();
      checks++; if (rise !== 4'b0000 || fall !== 4'b0000 || clean !== 4'b0000) begin errors++; $display("FAIL mid_wait rise=%b fall=%b clean=%b exp=0000/0000/0000", rise, fall, clean); end
    end
    step();
    checks++; if (rise !== 4'b1000 || clean !== 4'b1000) begin errors++; $display("FAIL mid_rise rise=%b clean=%b exp=1000/1000", rise, clean); end
    step();
    checks++; if (mask !== 4'b1000) begin errors++; $display("FAIL mid_event mask=%b exp=1000", mask); end
    ready = 1'b1;
    step();
    ready = 1'b0;
  endtask

  task automatic test_simul_fall();
    raw = 4'b1111;
    repeat (6) step();
    checks++; if (rise !== 4'b0111 || clean !== 4'b1111) begin errors++; $display("FAIL simul_rise rise=%b clean=%b exp=0111/1111", rise, clean); end
    step();
    checks++; if (mask !== 4'b0111) begin errors++; $display("FAIL simul_rise_mask mask=%b exp=0111", mask); end
    ready = 1'b1;
    step();
    ready = 1'b0;
    raw = 4'b0000;
    repeat (6) step();
    checks++; if (fall !== 4'b1111 || rise !== 4'b0000 || clean !== 4'b0000) begin errors++; $display("FAIL simul_fall fall=%b rise=%b clean=%b exp=1111/0000/0000", fall, rise, clean); end
    step();
    checks++; if (mask !== 4'b1111 || valid !== 1'b1 || fall !== 4'b0000) begin errors++; $display("FAIL simul_mask mask=%b valid=%b fall=%b exp=1111/1/0000", mask, valid, fall); end
    ready = 1'b1;
    step();
    ready = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL simul_ack valid=%b exp=0", valid); end
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_bounce();
    test_collision();
    test_reset_mid();
    test_simul_fall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
